// File: rtl/crop_pkg.sv
// Shared types and helpers for the crop stream sequencer.
//   crop_state_e : sequencer FSM states
//   crop_desc_t  : crop-origin descriptor (window top row y, left column x)
//   coord_w()    : counter/coordinate width for a dimension, at least 1 bit
package crop_pkg;

  // Descriptors carry coordinates at a fixed width so the struct does not depend on module
  // parameters; unused upper bits are always zero.
  localparam int unsigned CoordW = 16;

  typedef enum logic [0:0] {
    StWaitDesc,
    StStream
  } crop_state_e;

  typedef struct packed {
    logic [CoordW-1:0] y;
    logic [CoordW-1:0] x;
  } crop_desc_t;

  function automatic int unsigned coord_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned y_w(input int unsigned in_rows);
    return coord_w(in_rows);
  endfunction

  function automatic int unsigned x_w(input int unsigned in_cols);
    return coord_w(in_cols);
  endfunction

endpackage

// File: rtl/crop_desc_fifo.sv
// Synchronous descriptor FIFO.
//   clk_i, rst_ni      : clock, asynchronous active-low reset (empties the FIFO)
//   push_i, data_i     : write a descriptor (ignored while full)
//   pop_i, data_o      : drop the head entry (ignored while empty); data_o shows the head
//   full_o, empty_o    : occupancy flags, derived from the registered count
module crop_desc_fifo
  import crop_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  crop_desc_t data_i,
  input  logic       pop_i,
  output crop_desc_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  crop_desc_t      mem_q [Depth];
  logic            do_push, do_pop;

  always_comb begin
    full_o  = (count_q == Depth[PtrW:0]);
    empty_o = (count_q == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    data_o  = mem_q[rd_ptr_q];
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/crop_stream_sequencer.sv
// Runtime-programmable crop controller.
//   cfg_valid_i/cfg_ready_o/cfg_y_i/cfg_x_i : descriptor handshake; out-of-range descriptors
//                                             are discarded and flagged on cfg_err_o next cycle
//   pixel_in_i/in_valid_i/in_ready_o        : raster input, IN_ROWS x IN_COLS per frame
//   pixel_out_o/out_valid_o/out_ready_i     : cropped output, registered (latency 1)
//   out_last_o                              : marks the final pixel of a crop window
//   frame_done_o                            : one-cycle pulse after a frame's last input pixel
//   crops_done_o                            : completed-frame counter, wraps at 2^16
module crop_stream_sequencer
  import crop_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH = 8,
  parameter int unsigned IN_ROWS         = 9,
  parameter int unsigned IN_COLS         = 9,
  parameter int unsigned OUT_ROWS        = 3,
  parameter int unsigned OUT_COLS        = 3,
  parameter int unsigned DESC_DEPTH      = 2,
  localparam int unsigned YW             = y_w(IN_ROWS),
  localparam int unsigned XW             = x_w(IN_COLS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [YW-1:0]              cfg_y_i,
  input  logic [XW-1:0]              cfg_x_i,
  output logic                       cfg_err_o,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       out_last_o,
  output logic                       frame_done_o,
  output logic [15:0]                crops_done_o
);

  localparam int unsigned RW = coord_w(IN_ROWS);
  localparam int unsigned CW = coord_w(IN_COLS);

  crop_state_e state_q, state_d;

  logic [RW-1:0]              row_q;
  logic [CW-1:0]              col_q;
  crop_desc_t                 act_q;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_out_q;
  logic                       out_valid_q, out_last_q, frame_done_q, cfg_err_q;
  logic [15:0]                crops_done_q;

  crop_desc_t fifo_head, cfg_desc;
  logic       fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic       cfg_fire, cfg_ok;
  logic       in_fire, keep, last_kept, row_end, frame_end;
  logic [CoordW-1:0] row_c, col_c;

  // Config path
  always_comb begin
    cfg_desc    = '{y: CoordW'(cfg_y_i), x: CoordW'(cfg_x_i)};
    cfg_ready_o = !fifo_full;
    cfg_fire    = cfg_valid_i && cfg_ready_o;
    cfg_ok      = (cfg_desc.y <= CoordW'(IN_ROWS - OUT_ROWS)) &&
                  (cfg_desc.x <= CoordW'(IN_COLS - OUT_COLS));
    fifo_push   = cfg_fire && cfg_ok;
  end

  crop_desc_fifo #(
    .Depth (DESC_DEPTH)
  ) u_desc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (cfg_desc),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StWaitDesc;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitDesc: if (!fifo_empty) state_d = StStream;
      StStream:   if (in_fire && frame_end) state_d = StWaitDesc;
      default:    state_d = StWaitDesc;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_o = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      StWaitDesc: fifo_pop   = !fifo_empty;
      StStream:   in_ready_o = !out_valid_q || out_ready_i;
      default: ;
    endcase
  end

  // Window decode for the pixel currently offered
  always_comb begin
    in_fire   = in_valid_i && in_ready_o;
    row_c     = CoordW'(row_q);
    col_c     = CoordW'(col_q);
    keep      = (row_c >= act_q.y) && (row_c < act_q.y + CoordW'(OUT_ROWS)) &&
                (col_c >= act_q.x) && (col_c < act_q.x + CoordW'(OUT_COLS));
    last_kept = (row_c == act_q.y + CoordW'(OUT_ROWS - 1)) &&
                (col_c == act_q.x + CoordW'(OUT_COLS - 1));
    row_end   = (col_q == CW'(IN_COLS - 1));
    frame_end = row_end && (row_q == RW'(IN_ROWS - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q        <= '0;
      col_q        <= '0;
      act_q        <= '0;
      pixel_out_q  <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      crops_done_q <= '0;
    end else begin
      cfg_err_q    <= cfg_fire && !cfg_ok;
      frame_done_q <= in_fire && frame_end;

      if (fifo_pop) act_q <= fifo_head;

      if (in_fire) begin
        if (frame_end) begin
          row_q        <= '0;
          col_q        <= '0;
          crops_done_q <= crops_done_q + 16'd1;
        end else if (row_end) begin
          row_q <= row_q + RW'(1);
          col_q <= '0;
        end else begin
          col_q <= col_q + CW'(1);
        end
      end

      // A dropped pixel only retires the output register if downstream took it.
      if (in_fire && keep) begin
        pixel_out_q <= pixel_in_i;
        out_valid_q <= 1'b1;
        out_last_q  <= last_kept;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign pixel_out_o  = pixel_out_q;
  assign out_valid_o  = out_valid_q;
  assign out_last_o   = out_last_q;
  assign frame_done_o = frame_done_q;
  assign cfg_err_o    = cfg_err_q;
  assign crops_done_o = crops_done_q;

endmodule

// File: doc/crop_stream_sequencer.md
Name: crop_stream_sequencer

Overview:
- Runtime-programmable crop controller for the pixel-stream crop path.
- Accepts crop-origin descriptors (y, x) on a config handshake and queues them.
- Binds one descriptor to each incoming IN_ROWS x IN_COLS raster frame.
- Forwards only the pixels inside the OUT_ROWS x OUT_COLS window, drops the rest, and stalls input while no descriptor is pending.

Parameters:
PIXEL_BIT_WIDTH, 8, pixel word width
IN_ROWS, 9, input frame rows
IN_COLS, 9, input frame columns
OUT_ROWS, 3, crop window rows
OUT_COLS, 3, crop window columns
DESC_DEPTH, 2, descriptor queue depth (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
cfg_valid  in  1  descriptor offered
cfg_ready  out  1  descriptor queue not full
cfg_y  in  YW  window top row; YW = max(1,$clog2(IN_ROWS))
cfg_x  in  XW  window left column; XW = max(1,$clog2(IN_COLS))
cfg_err  out  1  one-cycle pulse: last accepted descriptor was out of range and discarded
pixel_in  in  PIXEL_BIT_WIDTH  raster pixel
in_valid  in  1  pixel_in valid
in_ready  out  1  sequencer accepts pixel
pixel_out  out  PIXEL_BIT_WIDTH  cropped pixel
out_valid  out  1  pixel_out valid
out_ready  in  1  downstream accepts
out_last  out  1  qualifies the final pixel of the current crop
frame_done  out  1  one-cycle pulse after a frame's last pixel is accepted
crops_done  out  16  count of completed frames, wraps at 2^16

Behaviour:
- Reset (reset=0, async): queue empty, state WAIT_DESC, row/col counters 0. Outputs go to cfg_ready=1, in_ready=0, out_valid=0, out_last=0, cfg_err=0, frame_done=0, crops_done=0, pixel_out=0. Mid-frame reset discards the partial frame and the queue.
- Config accept: cfg_valid & cfg_ready.
  - Valid iff cfg_y <= IN_ROWS-OUT_ROWS and cfg_x <= IN_COLS-OUT_COLS; only valid descriptors are pushed.
  - Invalid: no push; cfg_err=1 on the next cycle.
  - cfg_ready = !full (registered-count based). A pop while full frees the slot the next cycle; no same-cycle pass-through.
- States:
  - WAIT_DESC: in_ready=0. If queue non-empty: latch head into active window regs, pop, go to STREAM the next cycle. This gives a one-cycle bubble between frames.
  - STREAM: in_ready = !out_valid | out_ready.
    - On each accept, advance col; wrap col at IN_COLS-1 and increment row.
    - A pixel is kept iff y <= row < y+OUT_ROWS and x <= col < x+OUT_COLS.
    - Kept pixel: registered into pixel_out, out_valid=1 next cycle (latency 1); out_last=1 if row==y+OUT_ROWS-1 and col==x+OUT_COLS-1.
    - Dropped pixel: consumed; out_valid is cleared if out_ready was high, otherwise held.
    - Accepting pixel (IN_ROWS-1, IN_COLS-1): counters reset to 0, frame_done=1 next cycle, crops_done++, go to WAIT_DESC.
- Output hold: while out_valid & !out_ready, pixel_out and out_last stay stable and in_ready=0.
- The last kept pixel may still be pending in WAIT_DESC; it drains normally.
- Simultaneous cfg push and WAIT_DESC pop in the same cycle: both take effect, count unchanged.

Decomposition:
- Package crop_pkg:
  - YW/XW width functions
  - state enum {WAIT_DESC, STREAM}
  - descriptor struct {y, x}
- Sub-module crop_desc_fifo: synchronous FIFO of descriptors with DESC_DEPTH entries, push/pop, full/empty flags, async active-low reset.

Test Plan:
All scenarios use 9x9 frames, 3x3 crop, and index data where pixel = row*9+col.
1. Push (2,2); stream 0..80 with in_valid=out_ready=1 -> outputs 20,21,22,29,30,31,38,39,40; out_last only on 40; frame_done pulses once, the cycle after 80 is accepted; crops_done=1.
2. in_valid=1 with an empty queue for 20 cycles -> in_ready stays 0. Push (0,0) at cycle k -> in_ready=1 at k+2; outputs 0,1,2,9,10,11,18,19,20.
3. Push (7,2) -> cfg_err pulse and no queue change. Push (6,6) -> outputs 60,61,62,69,70,71,78,79,80.
4. Queue (0,0) then (6,6); stream two frames with random in_valid/out_ready -> 18 outputs in order, with no drop or duplicate. The same random pattern also fills the queue: with 2 entries held, cfg_ready=0 until the first pop.
5. Hold out_ready=0 after 20 is produced -> pixel_out=20 and out_valid=1 stable, in_ready=0. Release -> 21 follows.
6. Assert reset after 40 pixels of a frame with (2,2) queued -> out_valid=0, cfg_ready=1, queue empty. After release: in_ready=0 until a new descriptor is pushed, and the new frame starts at row 0, col 0.
